// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative 32-bit MULT/MULTU/DIV/DIVU unit writing HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    logic [5:0]  r_count;
    logic        r_is_div;
    logic        r_neg_lo;
    logic        r_neg_hi;
    logic        r_div_zero;
    logic [31:0] r_opb;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_a_orig;

    // op[0] marks the signed variants; op[1] selects divide
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    logic [32:0] w_sum;
    logic [31:0] w_mul_hi;
    logic [31:0] w_mul_lo;

    logic [32:0] w_shift_rem;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;

    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    always_comb begin
        w_a_neg = op[0] & a[31];
        w_b_neg = op[0] & b[31];
        w_a_mag = w_a_neg ? (~a + 32'd1) : a;
        w_b_mag = w_b_neg ? (~b + 32'd1) : b;

        w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : 33'd0);
        w_mul_hi = w_sum[32:1];
        w_mul_lo = {w_sum[0], r_acc_lo[31:1]};

        // Bit 32 of the 33-bit difference doubles as the borrow flag
        w_shift_rem = {r_acc_hi, r_acc_lo[31]};
        w_diff      = w_shift_rem - {1'b0, r_opb};
        w_ge        = ~w_diff[32];
        w_div_hi    = w_ge ? w_diff[31:0] : w_shift_rem[31:0];
        w_div_lo    = {r_acc_lo[30:0], w_ge};

        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_fix = r_neg_lo ? (~w_prod + 64'd1) : w_prod;
        w_quo_fix  = r_neg_lo ? (~r_acc_lo + 32'd1) : r_acc_lo;
        w_rem_fix  = r_neg_hi ? (~r_acc_hi + 32'd1) : r_acc_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 6'd0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_opb      <= 32'd0;
            r_acc_hi   <= 32'd0;
            r_acc_lo   <= 32'd0;
            r_a_orig   <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_count    <= 6'd0;
                        r_is_div   <= op[1];
                        r_neg_lo   <= w_a_neg ^ w_b_neg;
                        r_neg_hi   <= w_a_neg;
                        r_div_zero <= op[1] & (b == 32'd0);
                        r_a_orig   <= a;
                        r_acc_hi   <= 32'd0;
                        r_acc_lo   <= op[1] ? w_a_mag : w_b_mag;
                        r_opb      <= op[1] ? w_b_mag : w_a_mag;
                        busy       <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc_hi <= w_div_hi;
                        r_acc_lo <= w_div_lo;
                    end else begin
                        r_acc_hi <= w_mul_hi;
                        r_acc_lo <= w_mul_lo;
                    end
                    if (r_count == c_LAST_ITER) begin
                        r_count <= 6'd0;
                        r_state <= S_FINISH;
                    end else begin
                        r_count <= r_count + 6'd1;
                    end
                end
                S_FINISH: begin
                    if (r_is_div && r_div_zero) begin
                        hi <= r_a_orig;
                        lo <= 32'hFFFF_FFFF;
                    end else if (r_is_div) begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end else begin
                        hi <= w_prod_fix[63:32];
                        lo <= w_prod_fix[31:0];
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Randomized self-checking bench for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_pass;
    int          cyc;
    int          last_done;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .start (start),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    endtask

    // Reference result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int     sx;
        int     sy;
        longint q;
        longint r;
        logic [63:0] res;
        sx = x;
        sy = y;
        case (o)
            2'b00: res = {32'd0, x} * {32'd0, y};
            2'b01: res = longint'(sx) * longint'(sy);
            2'b10: res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q   = longint'(sx) / longint'(sy);
                    r   = longint'(sx) % longint'(sy);
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        logic [31:0] ph;
        logic [31:0] pl;
        logic        ok;
        ph = exp_hi;
        pl = exp_lo;
        r  = model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        ok = (busy === 1'b1) && (done === 1'b0) && (hi === ph) && (lo === pl);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == 10) begin
                start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd10;
            end else begin
                start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            if (!((busy === 1'b1) && (done === 1'b0) && (hi === ph) && (lo === pl))) ok = 1'b0;
        end
        // Start in the FINISH cycle must be ignored; it stays high into the done cycle
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd10;
        @(posedge clk); #1;
        check({tag, "_hold"}, 64'(ok), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(r[63:32]));
        check({tag, "_lo"}, 64'(lo), 64'(r[31:0]));
        if (last_done >= 0) check({tag, "_gap"}, 64'(cyc - last_done), 64'd34);
        last_done = cyc;
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    initial begin
        logic        saw_done;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        n_checks  = 0;
        n_pass    = 0;
        last_done = -1;
        exp_hi    = 32'd0;
        exp_lo    = 32'd0;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Abort an in-flight MULTU at iteration 10
        @(negedge clk);
        op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        run_op("multu_full", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg",   2'b01, 32'hFFFF_FFFA, 32'd7);
        run_op("divu",       2'b10, 32'd25, 32'd7);
        run_op("div_neg",    2'b11, 32'hFFFF_FFE7, 32'd7);
        run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero",  2'b10, 32'd12, 32'd0);
        run_op("div_zero",   2'b11, 32'hFFFF_FFF0, 32'd0);
        run_op("multu_3x4",  2'b00, 32'd3, 32'd4);

        for (int n = 0; n < 24; n++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = $urandom_range(1, 20);
                default: y = $urandom;
            endcase
            run_op("rand", o, x, y);
        end

        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
